// File: rtl/vga_frame_reader_if.sv
// Pixel-memory read port between the frame reader (master) and the frame buffer (slave).
// Data follows the address by the reader's configured read latency.
interface vga_frame_reader_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BPC    = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic [3*BPC-1:0]  mem_rdata;

  modport master (output mem_addr, input mem_rdata);
  modport slave  (input mem_addr, output mem_rdata);
endinterface

// File: rtl/vga_frame_reader.sv
// VGA frame reader: walks an integer-upscaled image with counters only, fetches pixels and
// emits colour aligned with the delayed sync signals; also offers bar, solid and grid modes.
module vga_frame_reader #(
  parameter int unsigned      IMG_W      = 100,
  parameter int unsigned      IMG_H      = 100,
  parameter int unsigned      SCALE      = 1,
  parameter int unsigned      BPC        = 8,
  parameter int unsigned      ADDR_W     = 32,
  parameter int unsigned      RD_LAT     = 1,
  parameter int unsigned      H_ACTIVE   = 640,
  parameter logic [3*BPC-1:0] BORDER_RGB = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_ce,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               video_on,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [1:0]         mode,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [3*BPC-1:0]   solid_rgb,
  vga_frame_reader_if.master mem,
  output logic               hsync,
  output logic               vsync,
  output logic [BPC-1:0]     r,
  output logic [BPC-1:0]     g,
  output logic [BPC-1:0]     b
);
  localparam int unsigned       WIN_W    = IMG_W * SCALE;
  localparam int unsigned       WIN_H    = IMG_H * SCALE;
  localparam int unsigned       BAR_W    = H_ACTIVE / 8;
  localparam logic [2:0]        SUB_LAST = 3'(SCALE - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W * 3);
  localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(3);

  // Syncs travel inverted so that a cleared stage reads as an inactive sync.
  typedef struct packed {
    logic       von;
    logic       hs_n;
    logic       vs_n;
    logic       win;
    logic       grid;
    logic [2:0] bar;
    logic [1:0] mode;
  } stage_t;

  logic              armed_q;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] base_q;
  logic [3*BPC-1:0]  solid_q;
  logic [2:0]        col_sub_q, row_sub_q;
  logic [ADDR_W-1:0] col_off_q, row_base_q;
  stage_t            dly_q [RD_LAT+1];

  logic              frame_start, armed, in_win, grid;
  logic [1:0]        cur_mode;
  logic [2:0]        bar, cur_col_sub, nxt_col_sub, cur_row_sub;
  logic [ADDR_W-1:0] cur_base, cur_col_off, nxt_col_off, cur_row_base;
  stage_t            stage_in, last;
  logic [3*BPC-1:0]  colour;

  always_comb begin
    frame_start = (x == '0) && (y == '0);
    // Addressing stays idle after reset until a full frame start has been seen.
    armed    = frame_start || armed_q;
    cur_mode = frame_start ? mode : mode_q;
    cur_base = frame_start ? base_addr : base_q;
    in_win   = armed && (32'(x) < WIN_W) && (32'(y) < WIN_H);
    grid     = (x[4:0] == '0) || (y[4:0] == '0);
    bar      = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (32'(x) >= k * BAR_W) bar = 3'(k);
    end

    cur_col_sub = (x == '0) ? '0 : col_sub_q;
    cur_col_off = (x == '0) ? '0 : col_off_q;
    if (cur_col_sub == SUB_LAST) begin
      nxt_col_sub = '0;
      nxt_col_off = cur_col_off + COL_STEP;
    end else begin
      nxt_col_sub = cur_col_sub + 3'd1;
      nxt_col_off = cur_col_off;
    end

    // Row state belongs to the current line; it steps at x=0 of each new image line only.
    cur_row_sub  = row_sub_q;
    cur_row_base = row_base_q;
    if (frame_start) begin
      cur_row_sub  = '0;
      cur_row_base = '0;
    end else if ((x == '0) && (32'(y) < WIN_H)) begin
      if (row_sub_q == SUB_LAST) begin
        cur_row_sub  = '0;
        cur_row_base = row_base_q + ROW_STEP;
      end else begin
        cur_row_sub = row_sub_q + 3'd1;
      end
    end

    stage_in.von  = video_on;
    stage_in.hs_n = ~hsync_in;
    stage_in.vs_n = ~vsync_in;
    stage_in.win  = in_win;
    stage_in.grid = grid;
    stage_in.bar  = bar;
    stage_in.mode = cur_mode;

    last   = dly_q[RD_LAT];
    colour = '0;
    if (last.von) begin
      case (last.mode)
        2'd0:    colour = last.win ? mem.mem_rdata : BORDER_RGB;
        2'd1:    colour = {{BPC{~last.bar[0]}}, {BPC{~last.bar[2]}}, {BPC{~last.bar[1]}}};
        2'd2:    colour = solid_q;
        default: colour = last.grid ? '1 : '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed_q      <= 1'b0;
      mode_q       <= '0;
      base_q       <= '0;
      solid_q      <= '0;
      col_sub_q    <= '0;
      col_off_q    <= '0;
      row_sub_q    <= '0;
      row_base_q   <= '0;
      mem.mem_addr <= '0;
      for (int i = 0; i <= int'(RD_LAT); i++) dly_q[i] <= '0;
      hsync        <= 1'b1;
      vsync        <= 1'b1;
      r            <= '0;
      g            <= '0;
      b            <= '0;
    end else if (pix_ce) begin
      armed_q <= armed;
      if (frame_start) begin
        mode_q  <= mode;
        base_q  <= base_addr;
        solid_q <= solid_rgb;
      end
      if (armed) begin
        col_sub_q  <= nxt_col_sub;
        col_off_q  <= nxt_col_off;
        row_sub_q  <= cur_row_sub;
        row_base_q <= cur_row_base;
      end
      if (in_win && (cur_mode == 2'd0)) begin
        mem.mem_addr <= cur_base + cur_row_base + cur_col_off;
      end
      dly_q[0] <= stage_in;
      for (int i = 1; i <= int'(RD_LAT); i++) dly_q[i] <= dly_q[i-1];
      hsync     <= ~last.hs_n;
      vsync     <= ~last.vs_n;
      {b, g, r} <= colour;
    end
  end
endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader: a SCALE=1 and a SCALE=2 instance share one stimulus
// stream; each memory returns its own low address bits as pixel data after one tick.
module tb_vga_frame_reader;
  logic        clk = 1'b0;
  logic        reset, pix_ce;
  logic [9:0]  x, y;
  logic        video_on, hsync_in, vsync_in;
  logic [1:0]  mode;
  logic [31:0] base_addr;
  logic [23:0] solid_rgb;
  logic        hs1, vs1, hs2, vs2;
  logic [7:0]  r1, g1, b1, r2, g2, b2;
  int          checks = 0;
  int          passed = 0;

  vga_frame_reader_if #(.ADDR_W(32), .BPC(8)) mif1 ();
  vga_frame_reader_if #(.ADDR_W(32), .BPC(8)) mif2 ();

  vga_frame_reader #(.SCALE(1), .BORDER_RGB(24'h123456)) dut1 (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .x(x), .y(y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .mode(mode), .base_addr(base_addr),
    .solid_rgb(solid_rgb), .mem(mif1), .hsync(hs1), .vsync(vs1), .r(r1), .g(g1), .b(b1)
  );

  vga_frame_reader #(.SCALE(2), .BORDER_RGB(24'h123456)) dut2 (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .x(x), .y(y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .mode(mode), .base_addr(base_addr),
    .solid_rgb(solid_rgb), .mem(mif2), .hsync(hs2), .vsync(vs2), .r(r2), .g(g2), .b(b2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pix_ce) begin
      mif1.mem_rdata <= mif1.mem_addr[23:0];
      mif2.mem_rdata <= mif2.mem_addr[23:0];
    end
  end

  task automatic tick(input logic [9:0] xx, input logic [9:0] yy);
    x = xx; y = yy; pix_ce = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    x = 10'h3FF; y = 10'h3FF; pix_ce = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; video_on = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    mode = 2'd0; base_addr = 32'h0; solid_rgb = 24'h0;
    tick(10'd3, 10'd3); tick(10'd4, 10'd3); tick(10'd5, 10'd3);
    checks++; if ({b1, g1, r1} !== 24'h0) $display("FAIL rst_rgb got %h want 0", {b1, g1, r1});
    else passed++;
    checks++; if (hs1 !== 1'b1) $display("FAIL rst_hsync got %b want 1", hs1); else passed++;
    checks++; if (vs1 !== 1'b1) $display("FAIL rst_vsync got %b want 1", vs1); else passed++;
    checks++; if (mif1.mem_addr !== 32'h0) $display("FAIL rst_addr got %h want 0", mif1.mem_addr);
    else passed++;
    reset = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
  endtask

  task automatic test_image();
    for (int yy = 0; yy < 2; yy++) for (int i = 0; i < 4; i++) tick(10'(i), 10'(yy));
    for (int i = 0; i < 5; i++) tick(10'(i), 10'd2);
    hsync_in = 1'b0; vsync_in = 1'b0;
    tick(10'd5, 10'd2);
    hsync_in = 1'b1; vsync_in = 1'b1;
    checks++; if (mif1.mem_addr !== 32'd615) $display("FAIL img_addr got %0d want 615", mif1.mem_addr);
    else passed++;
    checks++; if (mif2.mem_addr !== 32'd306) $display("FAIL img_addr_s2 got %0d want 306", mif2.mem_addr);
    else passed++;
    tick(10'd6, 10'd2);
    checks++; if (hs1 !== 1'b1) $display("FAIL img_hs_early got %b want 1", hs1); else passed++;
    tick(10'd7, 10'd2);
    checks++; if ({b1, g1, r1} !== 24'h000267) $display("FAIL img_rgb got %h want 000267", {b1, g1, r1});
    else passed++;
    checks++; if ({b2, g2, r2} !== 24'h000132) $display("FAIL img_rgb_s2 got %h want 000132", {b2, g2, r2});
    else passed++;
    checks++; if (hs1 !== 1'b0) $display("FAIL img_hs_delay got %b want 0", hs1); else passed++;
    checks++; if (vs1 !== 1'b0) $display("FAIL img_vs_delay got %b want 0", vs1); else passed++;
  endtask

  task automatic test_scale2();
    logic [31:0] exp_s2 [4];
    exp_s2[0] = 32'h1000; exp_s2[1] = 32'h1000; exp_s2[2] = 32'h1003; exp_s2[3] = 32'h1003;
    base_addr = 32'h1000;
    for (int i = 0; i < 4; i++) begin
      tick(10'(i), 10'd0);
      checks++;
      if (mif2.mem_addr !== exp_s2[i])
        $display("FAIL s2_col%0d got %h want %h", i, mif2.mem_addr, exp_s2[i]);
      else passed++;
    end
    checks++; if (mif1.mem_addr !== 32'h1009) $display("FAIL s1_col3 got %h want 1009", mif1.mem_addr);
    else passed++;
    tick(10'd0, 10'd1);
    checks++; if (mif2.mem_addr !== 32'h1000) $display("FAIL s2_row1 got %h want 1000", mif2.mem_addr);
    else passed++;
    tick(10'd0, 10'd2);
    checks++; if (mif2.mem_addr !== 32'h112C) $display("FAIL s2_row2 got %h want 112c", mif2.mem_addr);
    else passed++;
    checks++; if (mif1.mem_addr !== 32'h1258) $display("FAIL s1_row2 got %h want 1258", mif1.mem_addr);
    else passed++;
  endtask

  task automatic test_border();
    for (int yy = 3; yy <= 40; yy++) tick(10'd0, 10'(yy));
    checks++; if (mif1.mem_addr !== 32'h3EE0) $display("FAIL row40 got %h want 3ee0", mif1.mem_addr);
    else passed++;
    checks++; if (mif2.mem_addr !== 32'h2770) $display("FAIL row40_s2 got %h want 2770", mif2.mem_addr);
    else passed++;
    tick(10'd150, 10'd40);
    checks++; if (mif1.mem_addr !== 32'h3EE0) $display("FAIL border_hold got %h want 3ee0", mif1.mem_addr);
    else passed++;
    tick(10'd151, 10'd40); tick(10'd152, 10'd40);
    checks++; if ({b1, g1, r1} !== 24'h123456) $display("FAIL border_rgb got %h want 123456", {b1, g1, r1});
    else passed++;
    video_on = 1'b0;
    tick(10'd153, 10'd40);
    video_on = 1'b1;
    tick(10'd154, 10'd40); tick(10'd155, 10'd40);
    checks++; if ({b1, g1, r1} !== 24'h0) $display("FAIL blank_rgb got %h want 0", {b1, g1, r1});
    else passed++;
  endtask

  task automatic test_mode_switch();
    for (int yy = 41; yy <= 98; yy++) tick(10'd0, 10'(yy));
    mode = 2'd1;
    tick(10'd0, 10'd99);
    checks++; if (mif1.mem_addr !== 32'h8404) $display("FAIL midswitch got %h want 8404", mif1.mem_addr);
    else passed++;
    tick(10'd1, 10'd99);
    checks++; if (mif1.mem_addr !== 32'h8407) $display("FAIL midswitch2 got %h want 8407", mif1.mem_addr);
    else passed++;
    tick(10'd0, 10'd200);
    tick(10'd0, 10'd0);
    checks++; if (mif1.mem_addr !== 32'h8407) $display("FAIL bars_hold got %h want 8407", mif1.mem_addr);
    else passed++;
    tick(10'd85, 10'd0); tick(10'd330, 10'd0); tick(10'd331, 10'd0);
    checks++; if ({b1, g1, r1} !== 24'h00FFFF) $display("FAIL bar_yellow got %h want 00ffff", {b1, g1, r1});
    else passed++;
    checks++; if ({b2, g2, r2} !== 24'h00FFFF) $display("FAIL bar_yellow_s2 got %h want 00ffff", {b2, g2, r2});
    else passed++;
    tick(10'd332, 10'd0);
    checks++; if ({b1, g1, r1} !== 24'hFF00FF) $display("FAIL bar_magenta got %h want ff00ff", {b1, g1, r1});
    else passed++;
  endtask

  task automatic test_solid_grid();
    mode = 2'd2; solid_rgb = 24'hABCDEF;
    tick(10'd0, 10'd0);
    solid_rgb = 24'h0;
    tick(10'd1, 10'd0); tick(10'd2, 10'd0);
    checks++; if ({b1, g1, r1} !== 24'hABCDEF) $display("FAIL solid got %h want abcdef", {b1, g1, r1});
    else passed++;
    tick(10'd3, 10'd0);
    checks++; if ({b1, g1, r1} !== 24'hABCDEF) $display("FAIL solid_latch got %h want abcdef", {b1, g1, r1});
    else passed++;
    mode = 2'd3;
    tick(10'd0, 10'd0); tick(10'd33, 10'd5); tick(10'd64, 10'd5); tick(10'd7, 10'd32);
    checks++; if ({b1, g1, r1} !== 24'h0) $display("FAIL grid_off got %h want 0", {b1, g1, r1});
    else passed++;
    tick(10'd8, 10'd33);
    checks++; if ({b1, g1, r1} !== 24'hFFFFFF) $display("FAIL grid_x got %h want ffffff", {b1, g1, r1});
    else passed++;
    tick(10'd9, 10'd33);
    checks++; if ({b1, g1, r1} !== 24'hFFFFFF) $display("FAIL grid_y got %h want ffffff", {b1, g1, r1});
    else passed++;
  endtask

  task automatic test_reset_mid();
    hsync_in = 1'b0; vsync_in = 1'b0; mode = 2'd0;
    tick(10'd320, 10'd120); tick(10'd321, 10'd120); tick(10'd322, 10'd120);
    checks++; if ({b1, g1, r1} !== 24'hFFFFFF) $display("FAIL pre_rst got %h want ffffff", {b1, g1, r1});
    else passed++;
    reset = 1'b0;
    #2;
    checks++; if ({b1, g1, r1} !== 24'h0) $display("FAIL mid_rst_rgb got %h want 0", {b1, g1, r1});
    else passed++;
    checks++; if (hs1 !== 1'b1 || vs1 !== 1'b1) $display("FAIL mid_rst_sync got %b%b want 11", hs1, vs1);
    else passed++;
    checks++; if (mif1.mem_addr !== 32'h0) $display("FAIL mid_rst_addr got %h want 0", mif1.mem_addr);
    else passed++;
    reset = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    tick(10'd323, 10'd120); tick(10'd0, 10'd50);
    checks++; if (mif1.mem_addr !== 32'h0) $display("FAIL unarmed got %h want 0", mif1.mem_addr);
    else passed++;
    base_addr = 32'h200;
    tick(10'd0, 10'd0);
    checks++; if (mif1.mem_addr !== 32'h200) $display("FAIL rearm got %h want 200", mif1.mem_addr);
    else passed++;
    tick(10'd1, 10'd0);
    checks++; if (mif1.mem_addr !== 32'h203) $display("FAIL rearm_col got %h want 203", mif1.mem_addr);
    else passed++;
  endtask

  task automatic test_ce_gaps();
    idle(); tick(10'd2, 10'd0); idle(); tick(10'd3, 10'd0); idle(); tick(10'd4, 10'd0); idle();
    hsync_in = 1'b0;
    tick(10'd5, 10'd0);
    hsync_in = 1'b1;
    checks++; if (mif1.mem_addr !== 32'h20F) $display("FAIL gap_addr got %h want 20f", mif1.mem_addr);
    else passed++;
    checks++; if ({b1, g1, r1} !== 24'h000209) $display("FAIL gap_rgb5 got %h want 000209", {b1, g1, r1});
    else passed++;
    idle();
    checks++; if (mif1.mem_addr !== 32'h20F) $display("FAIL gap_addr_hold got %h want 20f", mif1.mem_addr);
    else passed++;
    checks++; if ({b1, g1, r1} !== 24'h000209) $display("FAIL gap_rgb_hold got %h want 000209", {b1, g1, r1});
    else passed++;
    tick(10'd6, 10'd0);
    checks++; if ({b1, g1, r1} !== 24'h00020C) $display("FAIL gap_rgb6 got %h want 00020c", {b1, g1, r1});
    else passed++;
    idle();
    checks++; if (hs1 !== 1'b1) $display("FAIL gap_hs_hold got %b want 1", hs1); else passed++;
    tick(10'd7, 10'd0);
    checks++; if ({b1, g1, r1} !== 24'h00020F) $display("FAIL gap_rgb7 got %h want 00020f", {b1, g1, r1});
    else passed++;
    checks++; if (hs1 !== 1'b0) $display("FAIL gap_hs got %b want 0", hs1); else passed++;
  endtask

  initial begin
    test_reset();
    test_image();
    test_scale2();
    test_border();
    test_mode_switch();
    test_solid_grid();
    test_reset_mid();
    test_ce_gaps();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
